// File: rtl/link_monitor_pkg.sv
// rtl/link_monitor_pkg.sv - link monitor state encoding and default timing constants
// Timing defaults are shared with the descrambler's unlock-time constants.
package link_monitor_pkg;

   typedef enum logic [1:0] {
      ST_DOWN      = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_UP        = 2'd2,
      ST_RETRY     = 2'd3
   } lm_state_e;

   // Cycle counts at 125 MHz: 330 us stabilise, 500 us lock window.
   localparam logic [15:0] LM_STABLE_TIME      = 16'd41250;
   localparam logic [15:0] LM_TEST_STABLE_TIME = 16'd125;
   localparam logic [15:0] LM_LOCK_TIMEOUT     = 16'd62500;
   localparam logic [15:0] LM_RETRY_TIME       = 16'd16;

endpackage

// File: rtl/link_monitor.sv
// rtl/link_monitor.sv - 100BASE-TX descrambler sequencing and link status monitor
// Optional lock-loss statistics counter enabled by macro LINK_STATS_EN.
module link_monitor
   import link_monitor_pkg::*;
#(
   parameter logic [15:0] STABLE_TIME      = LM_STABLE_TIME,
   parameter logic [15:0] TEST_STABLE_TIME = LM_TEST_STABLE_TIME,
   parameter logic [15:0] LOCK_TIMEOUT     = LM_LOCK_TIMEOUT,
   parameter logic [15:0] RETRY_TIME       = LM_RETRY_TIME
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        signal_detect,
   input  logic        locked,
   input  logic        test_mode,
   output logic        descramble_enable,
   output logic        link_status,
   output logic        lock_fail
`ifdef LINK_STATS_EN
   ,
   output logic [15:0] lock_loss_count,
   input  logic        stats_clear
`endif
);

   lm_state_e   state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic        enable_q, link_q, lock_fail_q, lock_fail_d;
   logic [15:0] stable_reload;

   assign stable_reload = test_mode ? (TEST_STABLE_TIME - 16'd1) : (STABLE_TIME - 16'd1);

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      lock_fail_d = 1'b0;
      if (!signal_detect) begin
         state_d = ST_DOWN;
         timer_d = stable_reload;
      end else begin
         unique case (state_q)
            ST_DOWN: begin
               if (timer_q == 16'd0) begin
                  state_d = ST_WAIT_LOCK;
                  timer_d = LOCK_TIMEOUT - 16'd1;
               end else begin
                  timer_d = timer_q - 16'd1;
               end
            end
            ST_WAIT_LOCK: begin
               // Lock wins over an expiring timer on the same cycle.
               if (locked) begin
                  state_d = ST_UP;
               end else if (timer_q == 16'd0) begin
                  state_d     = ST_RETRY;
                  timer_d     = RETRY_TIME - 16'd1;
                  lock_fail_d = 1'b1;
               end else begin
                  timer_d = timer_q - 16'd1;
               end
            end
            ST_UP: begin
               if (!locked) begin
                  state_d     = ST_RETRY;
                  timer_d     = RETRY_TIME - 16'd1;
                  lock_fail_d = 1'b1;
               end
            end
            ST_RETRY: begin
               if (timer_q == 16'd0) begin
                  state_d = ST_WAIT_LOCK;
                  timer_d = LOCK_TIMEOUT - 16'd1;
               end else begin
                  timer_d = timer_q - 16'd1;
               end
            end
            default: state_d = ST_DOWN;
         endcase
      end
   end

   // Outputs are registered from the next state so they move with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_DOWN;
         timer_q     <= STABLE_TIME - 16'd1;
         enable_q    <= 1'b0;
         link_q      <= 1'b0;
         lock_fail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         enable_q    <= (state_d == ST_WAIT_LOCK) || (state_d == ST_UP);
         link_q      <= (state_d == ST_UP);
         lock_fail_q <= lock_fail_d;
      end
   end

   assign descramble_enable = enable_q;
   assign link_status       = link_q;
   assign lock_fail         = lock_fail_q;

`ifdef LINK_STATS_EN
   logic        loss_inc;
   logic [15:0] loss_cnt_q;

   assign loss_inc = (state_q == ST_UP) && signal_detect && !locked;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loss_cnt_q <= '0;
      end else if (stats_clear) begin
         loss_cnt_q <= '0;
      end else if (loss_inc && (loss_cnt_q != 16'hffff)) begin
         loss_cnt_q <= loss_cnt_q + 16'd1;
      end
   end

   assign lock_loss_count = loss_cnt_q;
`endif

endmodule

// File: tb/tb_link_monitor.sv
// tb/tb_link_monitor.sv - directed scoreboard bench for link_monitor
// Counter checks are active when LINK_STATS_EN is defined.
module tb_link_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        signal_detect;
   logic        locked;
   logic        test_mode;
   logic        descramble_enable;
   logic        link_status;
   logic        lock_fail;
`ifdef LINK_STATS_EN
   logic [15:0] lock_loss_count;
   logic        stats_clear;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   string       tag_q[$];
   logic [31:0] val_q[$];

   always #5 clk = ~clk;

   link_monitor #(
      .STABLE_TIME      (16'd16),
      .TEST_STABLE_TIME (16'd4),
      .LOCK_TIMEOUT     (16'd32),
      .RETRY_TIME       (16'd4)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .signal_detect     (signal_detect),
      .locked            (locked),
      .test_mode         (test_mode),
      .descramble_enable (descramble_enable),
      .link_status       (link_status),
      .lock_fail         (lock_fail)
`ifdef LINK_STATS_EN
      ,
      .lock_loss_count   (lock_loss_count),
      .stats_clear       (stats_clear)
`endif
   );

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      val_q.push_back(v);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      t = tag_q.pop_front();
      e = val_q.pop_front();
      n_cmp++;
      assert (obs === e) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      push(tag, exp_v);
      pop_chk(obs);
   endtask

   // Scoreboard snapshot of all three status outputs as {enable, link, lock_fail}.
   task automatic chk_out(input string tag, input logic [2:0] exp_v);
      push(tag, {29'd0, exp_v});
      pop_chk({29'd0, descramble_enable, link_status, lock_fail});
   endtask

   task automatic chk_cnt(input string tag, input logic [15:0] exp_v);
`ifdef LINK_STATS_EN
      chk(tag, {16'd0, lock_loss_count}, {16'd0, exp_v});
`else
      if (tag.len() < 0) $display("%s %0d", tag, exp_v);
`endif
   endtask

   task automatic set_clr(input logic v);
`ifdef LINK_STATS_EN
      stats_clear = v;
`else
      if (v === 1'bx) $display("clr");
`endif
   endtask

   initial begin
      rst_n = 1'b0; signal_detect = 1'b0; locked = 1'b0; test_mode = 1'b0;
      set_clr(1'b0);
      #12;
      chk_out("reset_outputs", 3'b000);
      chk_cnt("reset_count", 16'd0);
      rst_n = 1'b1;
      signal_detect = 1'b1;

      cyc(15);
      chk_out("stable_not_yet", 3'b000);
      cyc(1);
      chk_out("stable_enable", 3'b100);
      locked = 1'b1;
      cyc(1);
      chk_out("link_up", 3'b110);

      locked = 1'b0;
      cyc(1);
      chk_out("loss_retry_entry", 3'b001);
      chk_cnt("loss_count_1", 16'd1);
      cyc(1);
      chk_out("lock_fail_single", 3'b000);
      cyc(2);
      chk_out("retry_hold_low", 3'b000);
      cyc(1);
      chk_out("retry_to_wait", 3'b100);

      cyc(31);
      chk_out("wait_before_timeout", 3'b100);
      cyc(1);
      chk_out("timeout_retry", 3'b001);
      chk_cnt("timeout_not_counted", 16'd1);
      cyc(3);
      chk_out("timeout_retry_low", 3'b000);
      cyc(1);
      chk_out("timeout_rewait", 3'b100);
      cyc(31);
      chk_out("rewait_before_timeout", 3'b100);
      locked = 1'b1;
      cyc(1);
      chk_out("lock_at_timer_zero", 3'b110);

      signal_detect = 1'b0;
      test_mode = 1'b1;
      cyc(1);
      chk_out("sd_drop_down", 3'b000);
      chk_cnt("sd_drop_not_counted", 16'd1);
      cyc(1);
      signal_detect = 1'b1;
      cyc(3);
      chk_out("test_mode_not_yet", 3'b000);
      cyc(1);
      chk_out("test_mode_enable", 3'b100);
      cyc(1);
      chk_out("test_mode_link", 3'b110);
      test_mode = 1'b0;

      locked = 1'b0;
      set_clr(1'b1);
      cyc(1);
      chk_out("clear_loss_retry", 3'b001);
      chk_cnt("clear_priority", 16'd0);
      set_clr(1'b0);
      locked = 1'b1;
      cyc(3);
      chk_out("retry_ignores_lock", 3'b000);
      cyc(1);
      chk_out("relock_wait", 3'b100);
      cyc(1);
      chk_out("relock_up", 3'b110);

      signal_detect = 1'b0;
      cyc(1);
      chk_out("glitch_prep_down", 3'b000);
      signal_detect = 1'b1;
      cyc(10);
      signal_detect = 1'b0;
      cyc(1);
      chk_out("glitch_low", 3'b000);
      signal_detect = 1'b1;
      cyc(15);
      chk_out("glitch_no_early", 3'b000);
      cyc(1);
      chk_out("glitch_enable", 3'b100);
      cyc(1);
      chk_out("glitch_link", 3'b110);

      #2;
      rst_n = 1'b0;
      #1;
      chk_out("async_reset", 3'b000);
      chk_cnt("async_reset_count", 16'd0);
      cyc(1);
      rst_n = 1'b1;

      chk("scoreboard_drained", tag_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
